// File: rtl/mem_1rw_req_adapter_if.sv
// Request, SRAM-pin and response bundle around the 1RW SRAM request adapter.
// slave = adapter view; master = requester/SRAM/consumer environment view.
interface mem_1rw_req_adapter_if #(
    parameter int ELS   = 512,
    parameter int WIDTH = 64
);
    localparam int ADDR_W = $clog2(ELS);
    localparam int MASK_W = WIDTH / 8;

    logic              req_v_i;
    logic              req_ready_o;
    logic              req_w_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [WIDTH-1:0]  req_data_i;
    logic [MASK_W-1:0] req_mask_i;

    logic              sram_v_o;
    logic              sram_w_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [WIDTH-1:0]  sram_data_o;
    logic [MASK_W-1:0] sram_mask_o;
    logic [WIDTH-1:0]  sram_data_i;

    logic              resp_v_o;
    logic              resp_ready_i;
    logic [WIDTH-1:0]  resp_data_o;

    modport slave (
        input  req_v_i, req_w_i, req_addr_i, req_data_i, req_mask_i,
        output req_ready_o,
        output sram_v_o, sram_w_o, sram_addr_o, sram_data_o, sram_mask_o,
        input  sram_data_i,
        output resp_v_o, resp_data_o,
        input  resp_ready_i
    );

    modport master (
        output req_v_i, req_w_i, req_addr_i, req_data_i, req_mask_i,
        input  req_ready_o,
        input  sram_v_o, sram_w_o, sram_addr_o, sram_data_o, sram_mask_o,
        output sram_data_i,
        input  resp_v_o, resp_data_o,
        output resp_ready_i
    );
endinterface

// File: rtl/mem_1rw_req_adapter.sv
// Valid/ready front-end for a 1RW SRAM; reads return 2 cycles after accept via a 3-entry buffer.
// Backpressure: req_ready_o is registered and drops while buffered + in-flight reads reach 3.
module mem_1rw_req_adapter #(
    parameter int ELS   = 512,
    parameter int WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    mem_1rw_req_adapter_if.slave bus
);
    localparam int ADDR_W = $clog2(ELS);
    localparam int MASK_W = WIDTH / 8;

    logic             fire;
    logic             rd_fire;
    logic             enq;
    logic             deq;
    logic             rd_pend_q, rd_pend_d;
    logic             ready_q, ready_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0]       head_q, head_d;
    logic [1:0]       tail_q, tail_d;
    logic [2:0]       occ_d;
    logic [WIDTH-1:0] fifo_q [3];

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        fire      = bus.req_v_i & ready_q;
        rd_fire   = fire & ~bus.req_w_i;
        enq       = rd_pend_q;
        deq       = (cnt_q != 2'd0) & bus.resp_ready_i;
        rd_pend_d = rd_fire;
        cnt_d     = cnt_q;
        head_d    = head_q;
        tail_d    = tail_q;
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (enq) tail_d = ptr_inc(tail_q);
        if (deq) head_d = ptr_inc(head_q);
        // Ready is computed from next-state and registered, so resp_ready_i never reaches it combinationally.
        occ_d   = {1'b0, cnt_d} + {2'b00, rd_pend_d};
        ready_d = (occ_d < 3'd3);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_pend_q <= 1'b0;
            ready_q   <= 1'b0;
            cnt_q     <= 2'd0;
            head_q    <= 2'd0;
            tail_q    <= 2'd0;
        end else begin
            rd_pend_q <= rd_pend_d;
            ready_q   <= ready_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

    // SRAM data is only valid the cycle after the read, so capture is keyed off rd_pend alone.
    always_ff @(posedge clk_i) begin
        if (enq) fifo_q[tail_q] <= bus.sram_data_i;
    end

    assign bus.req_ready_o = ready_q;
    assign bus.sram_v_o    = fire;
    assign bus.sram_w_o    = fire & bus.req_w_i;
    assign bus.sram_addr_o = bus.req_addr_i;
    assign bus.sram_data_o = bus.req_data_i;
    assign bus.sram_mask_o = rd_fire ? {MASK_W{1'b0}} : bus.req_mask_i;
    assign bus.resp_v_o    = (cnt_q != 2'd0);
    assign bus.resp_data_o = fifo_q[head_q];

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(enq && cnt_q == 2'd3));

    logic unused_addr_w;
    assign unused_addr_w = (ADDR_W == 0);
endmodule

// File: tb/tb_mem_1rw_req_adapter.sv
// Bench for mem_1rw_req_adapter with a behavioural 1RW byte-masked SRAM and a response scoreboard.
module tb_mem_1rw_req_adapter;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_1rw_req_adapter_if #(.ELS(512), .WIDTH(64)) bus ();

    mem_1rw_req_adapter #(.ELS(512), .WIDTH(64)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus.slave)
    );

    function automatic logic [63:0] pat(input int a);
        return {32'hC0DE0000 | 32'(a), 32'(a) * 32'h01010101};
    endfunction

    // Behavioural SRAM: unwritten words read as pat(addr).
    logic [63:0] mem [512];
    bit          mem_ok [512];
    logic [63:0] sram_rd;
    assign bus.sram_data_i = sram_rd;

    always @(posedge clk) begin
        if (bus.sram_v_o) begin
            if (bus.sram_w_o) begin
                logic [63:0] w;
                w = mem_ok[bus.sram_addr_o] ? mem[bus.sram_addr_o] : pat(int'(bus.sram_addr_o));
                for (int b = 0; b < 8; b++)
                    if (bus.sram_mask_o[b]) w[8*b +: 8] = bus.sram_data_o[8*b +: 8];
                mem[bus.sram_addr_o]    <= w;
                mem_ok[bus.sram_addr_o] <= 1'b1;
            end else begin
                sram_rd <= mem_ok[bus.sram_addr_o] ? mem[bus.sram_addr_o] : pat(int'(bus.sram_addr_o));
            end
        end
    end

    logic [63:0] ref_mem [512];
    logic [63:0] exp_q [$];
    int          resp_cyc [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.resp_v_o && bus.resp_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("resp_extra", 64'(bus.resp_v_o), 64'd0);
            end else begin
                chk("resp_data", bus.resp_data_o, exp_q.pop_front());
                resp_cyc.push_back(cyc);
            end
        end
    end

    task automatic idle();
        bus.req_v_i    = 1'b0;
        bus.req_w_i    = 1'b0;
        bus.req_addr_i = '0;
        bus.req_data_i = '0;
        bus.req_mask_i = '0;
    endtask

    // Call at posedge+1; returns at posedge+1 after the request fires, leaving it driven.
    task automatic do_req(input logic w, input logic [8:0] a, input logic [63:0] d, input logic [7:0] m);
        int wt;
        bit done;
        wt   = 0;
        done = 0;
        bus.req_v_i    = 1'b1;
        bus.req_w_i    = w;
        bus.req_addr_i = a;
        bus.req_data_i = d;
        bus.req_mask_i = m;
        while (!done) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                chk("sram_v", 64'(bus.sram_v_o), 64'd1);
                chk("sram_w", 64'(bus.sram_w_o), 64'(w));
                if (!w) chk("sram_mask_rd", 64'(bus.sram_mask_o), 64'd0);
                if (w) begin
                    for (int b = 0; b < 8; b++)
                        if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                end else begin
                    exp_q.push_back(ref_mem[a]);
                end
                done = 1;
            end else if (++wt > 50) begin
                chk("req_timeout", 64'(bus.req_ready_o), 64'd1);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 512; i++) ref_mem[i] = pat(i);
        rst_n = 1'b0;
        bus.resp_ready_i = 1'b1;
        idle();
        #12;
        chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
        chk("rst_resp_v", 64'(bus.resp_v_o), 64'd0);
        chk("rst_sram_v", 64'(bus.sram_v_o), 64'd0);
        chk("rst_sram_w", 64'(bus.sram_w_o), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", 64'(bus.req_ready_o), 64'd1);
        chk("idle_resp_v", 64'(bus.resp_v_o), 64'd0);
        chk("idle_sram_v", 64'(bus.sram_v_o), 64'd0);

        // Full write then read-back with latency probe
        do_req(1'b1, 9'd5, 64'h1122334455667788, 8'hFF);
        do_req(1'b0, 9'd5, 64'd0, 8'hFF);
        idle();
        @(negedge clk);
        chk("lat1_resp_v", 64'(bus.resp_v_o), 64'd0);
        chk("sram_w_once", 64'(bus.sram_w_o), 64'd0);
        chk("sram_v_idle", 64'(bus.sram_v_o), 64'd0);
        @(negedge clk);
        chk("lat2_resp_v", 64'(bus.resp_v_o), 64'd1);
        chk("lat2_data", bus.resp_data_o, 64'h1122334455667788);
        @(posedge clk);
        #1;
        wait_drain();

        // Partial byte mask over all-ones
        do_req(1'b1, 9'd7, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        do_req(1'b1, 9'd7, 64'd0, 8'h0F);
        do_req(1'b0, 9'd7, 64'd0, 8'h00);
        idle();
        wait_drain();

        // Stall: only 3 reads accepted while the consumer is blocked
        bus.resp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) do_req(1'b0, 9'(i), 64'd0, 8'h00);
        bus.req_v_i    = 1'b1;
        bus.req_w_i    = 1'b0;
        bus.req_addr_i = 9'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_ready", 64'(bus.req_ready_o), 64'd0);
            chk("stall_sram_v", 64'(bus.sram_v_o), 64'd0);
        end
        chk("stall_resp_v", 64'(bus.resp_v_o), 64'd1);
        @(posedge clk);
        #1;
        bus.resp_ready_i = 1'b1;
        do_req(1'b0, 9'd3, 64'd0, 8'h00);
        do_req(1'b0, 9'd4, 64'd0, 8'h00);
        idle();
        wait_drain();

        // 20 back-to-back reads; pointers wrap several times
        resp_cyc.delete();
        c0 = cyc;
        for (int i = 0; i < 20; i++) do_req(1'b0, 9'(100 + i), 64'd0, 8'h00);
        chk("b2b_accept_cycles", 64'(cyc - c0), 64'd20);
        idle();
        wait_drain();
        chk("b2b_resp_count", 64'(resp_cyc.size()), 64'd20);
        for (int i = 1; i < resp_cyc.size(); i++)
            chk("b2b_gap", 64'(resp_cyc[i] - resp_cyc[i-1]), 64'd1);

        // Reset with two reads in flight
        do_req(1'b0, 9'd9, 64'd0, 8'h00);
        do_req(1'b0, 9'd10, 64'd0, 8'h00);
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(bus.req_ready_o), 64'd0);
        chk("midrst_resp_v", 64'(bus.resp_v_o), 64'd0);
        chk("midrst_sram_v", 64'(bus.sram_v_o), 64'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_resp_v", 64'(bus.resp_v_o), 64'd0);
        end
        @(posedge clk);
        #1;
        do_req(1'b0, 9'd10, 64'd0, 8'h00);
        idle();
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
